// File: rtl/mul_issue_ctrl.sv
// -----------------------------------------------------------------------------
// mul_issue_ctrl
//
// Front/back-end controller for the iterative radix-4 Booth multiplier core.
// Decodes the 32-bit multiply op, sign/zero-extends the operands to 33 bits,
// issues the op to the core over a valid/ready port, captures the core's
// single-cycle result pulse, selects the low or high product word, and holds
// it for writeback under valid/ready backpressure. Zero operands bypass the
// core. A flush kills whatever op is held or in flight; an op already inside
// the core is allowed to finish and its product is discarded.
//
// Ports
//   clk, reset              clock; synchronous active-high reset
//   in_valid/in_ready       upstream op handshake
//   in_op                   00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   in_src1, in_src2        32-bit operands
//   in_tag                  opaque tag, returned with the result
//   flush                   kill any held or in-flight op
//   m_src1, m_src2          33-bit extended operands to the core
//   m_in_valid/m_in_ready   core issue handshake
//   m_out_valid, m_result   core one-cycle result pulse and 64-bit product
//   out_valid/out_ready     writeback handshake
//   out_data, out_tag       selected result word and its tag
// -----------------------------------------------------------------------------
module mul_issue_ctrl #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_src1,
  input  logic [31:0]      in_src2,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic [32:0]      m_src1,
  output logic [32:0]      m_src2,
  output logic             m_in_valid,
  input  logic             m_in_ready,
  input  logic             m_out_valid,
  input  logic [63:0]      m_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHU  = 2'b11;

  logic [1:0]  state;
  logic        drop;     // the op inside the core was flushed; discard its product
  logic [1:0]  op_q;
  logic [32:0] src1_q;
  logic [32:0] src2_q;

  logic accept;
  logic sgn1;
  logic sgn2;
  logic zero_op;

  // in_ready stays low through WAIT, including a dropped op's WAIT, so the
  // core never holds more than one op and a stale pulse cannot be misattributed.
  assign in_ready = (state == S_IDLE) && !flush;
  assign accept   = in_valid && in_ready;

  assign sgn1    = (in_op != OP_MULHU);
  assign sgn2    = (in_op == OP_MUL) || (in_op == OP_MULH);
  assign zero_op = (in_src1 == 32'd0) || (in_src2 == 32'd0);

  assign m_in_valid = (state == S_ISSUE);
  assign m_src1     = src1_q;
  assign m_src2     = src2_q;
  assign out_valid  = (state == S_HOLD);

  // NOTE: all state here is updated with non-blocking assignments so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      drop      <= 1'b0;
      op_q      <= 2'b00;
      src1_q    <= '0;
      src2_q    <= '0;
      out_data  <= '0;
      out_tag   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q    <= in_op;
            out_tag <= in_tag;
            src1_q  <= {sgn1 & in_src1[31], in_src1};
            src2_q  <= {sgn2 & in_src2[31], in_src2};
            if (zero_op) begin
              // Product is zero for every op; skip the core entirely.
              out_data <= '0;
              state    <= S_HOLD;
            end else begin
              state <= S_ISSUE;
            end
          end
        end

        S_ISSUE: begin
          if (m_in_ready) begin
            // Handshake completes this edge even under flush; the core now
            // owns the op, so remember to throw its product away.
            state <= S_WAIT;
            drop  <= flush;
          end else if (flush) begin
            state <= S_IDLE;
          end
        end

        S_WAIT: begin
          if (m_out_valid) begin
            drop <= 1'b0;
            if (drop || flush) begin
              state <= S_IDLE;
            end else begin
              // The core presents the product for this cycle only.
              out_data <= (op_q == OP_MUL) ? m_result[31:0] : m_result[63:32];
              state    <= S_HOLD;
            end
          end else if (flush) begin
            drop <= 1'b1;
          end
        end

        S_HOLD: begin
          // Flush wins over a coincident out_ready: no transfer happens.
          if (flush || out_ready) begin
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mul_issue_ctrl
//
// Self-checking bench for mul_issue_ctrl. A behavioural multiplier core with
// random latency and random readiness sits on the core port. The driver
// pushes the expected result of every accepted op (computed with plain 64-bit
// arithmetic from the op's signedness rules) into a scoreboard queue; the
// monitor pops and compares whenever a writeback transfer happens. A flush
// empties the queue, since it kills the single outstanding op.
// -----------------------------------------------------------------------------
module tb_mul_issue_ctrl;

  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [31:0]      in_src1;
  logic [31:0]      in_src2;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic [32:0]      m_src1;
  logic [32:0]      m_src2;
  logic             m_in_valid;
  logic             m_in_ready;
  logic             m_out_valid;
  logic [63:0]      m_result;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [TAG_W-1:0] out_tag;

  mul_issue_ctrl #(.TAG_W(TAG_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_src1     (in_src1),
    .in_src2     (in_src2),
    .in_tag      (in_tag),
    .flush       (flush),
    .m_src1      (m_src1),
    .m_src2      (m_src2),
    .m_in_valid  (m_in_valid),
    .m_in_ready  (m_in_ready),
    .m_out_valid (m_out_valid),
    .m_result    (m_result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_tag     (out_tag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    logic             byp;
    int               acc;
    logic [32:0]      m1;
    logic [32:0]      m2;
  } exp_t;

  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  // Core model state (shared read-only with the driver).
  logic   busy = 1'b0;
  int     cnt  = 0;
  longint prod = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference result: extend each operand by its signedness, multiply, pick a word.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint x;
    longint y;
    longint p;
    x = (op != 2'b11) ? longint'($signed(a)) : longint'({32'b0, a});
    y = (op <= 2'b01) ? longint'($signed(b)) : longint'({32'b0, b});
    p = x * y;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // ---------------- behavioural multiplier core ----------------
  logic prev_hs = 1'b0;
  initial begin
    m_in_ready  = 1'b0;
    m_out_valid = 1'b0;
    m_result    = '0;
    forever begin
      @(negedge clk);
      m_out_valid = 1'b0;
      m_result    = {$urandom, $urandom};
      if (reset) begin
        busy       = 1'b0;
        m_in_ready = 1'b0;
        prev_hs    = 1'b0;
      end else begin
        if (prev_hs) check("m_in_valid_one_cycle", 64'(m_in_valid), 64'd0);
        if (busy) begin
          check("one_op_in_core", 64'(m_in_valid), 64'd0);
          if (cnt == 0) begin
            m_out_valid = 1'b1;
            m_result    = prod;
            busy        = 1'b0;
          end else begin
            cnt--;
          end
        end
        m_in_ready = !busy && ($urandom_range(3) != 0);
        prev_hs    = m_in_valid && m_in_ready;
        if (prev_hs) begin
          check("issue_has_op", 64'(sb.size() == 0), 64'd0);
          if (sb.size() != 0) begin
            check("bypass_never_issued", 64'(sb[0].byp), 64'd0);
            check("m_src1", 64'(m_src1), 64'(sb[0].m1));
            check("m_src2", 64'(m_src2), 64'(sb[0].m2));
          end
          prod = longint'($signed(m_src1)) * longint'($signed(m_src2));
          busy = 1'b1;
          cnt  = $urandom_range(4);
        end
      end
    end
  end

  // ---------------- monitor ----------------
  logic prev_ov = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        prev_ov = 1'b0;
      end else begin
        if (out_valid && !flush) begin
          check("unexpected_out", 64'(sb.size() == 0), 64'd0);
          if (sb.size() != 0) begin
            if (!prev_ov && sb[0].byp) check("bypass_latency", 64'(cyc - sb[0].acc), 64'd1);
            check("out_data", 64'(out_data), 64'(sb[0].data));
            check("out_tag", 64'(out_tag), 64'(sb[0].tag));
            if (out_ready) void'(sb.pop_front());
          end
        end
        prev_ov = out_valid;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [TAG_W-1:0] tg,
                       input logic fl, input logic ordy, output logic acc);
    exp_t e;
    @(negedge clk);
    in_valid  = v;
    in_op     = op;
    in_src1   = a;
    in_src2   = b;
    in_tag    = tg;
    flush     = fl;
    out_ready = ordy;
    #1;
    if (fl) sb.delete();
    acc = in_valid && in_ready;
    if (in_ready) check("in_ready_core_idle", 64'(busy), 64'd0);
    if (acc) begin
      check("in_ready_no_outstanding", 64'(sb.size()), 64'd0);
      e.data = model(op, a, b);
      e.tag  = tg;
      e.byp  = (a == 32'd0) || (b == 32'd0);
      e.acc  = cyc;
      e.m1   = {(op != 2'b11) & a[31], a};
      e.m2   = {(op <= 2'b01) & b[31], b};
      sb.push_back(e);
    end
  endtask

  logic [1:0]  d_op [7] = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00};
  logic [31:0] d_a  [7] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7,
                            32'd0, 32'd2, 32'd5};
  logic [31:0] d_b  [7] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
                            32'h1234, 32'd3, 32'd0};

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(7))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic acc;
    int   n;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_op     = 2'b00;
    in_src1   = '0;
    in_src2   = '0;
    in_tag    = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_m_in_valid", 64'(m_in_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    reset = 1'b0;

    // Directed vectors, each held until accepted.
    for (int i = 0; i < 7; i++) begin
      n = 0;
      do begin
        drive(1'b1, d_op[i], d_a[i], d_b[i], 5'(i + 3), 1'b0, 1'b1, acc);
        n++;
      end while (!acc && n < 200);
      check("directed_accept_timeout", 64'(acc), 64'd1);
    end

    // Random phase: random ops, backpressure and flushes.
    for (int i = 0; i < 1500; i++) begin
      drive(1'($urandom_range(1)), 2'($urandom_range(3)), rand_operand(), rand_operand(),
            TAG_W'($urandom), ($urandom_range(15) == 0), ($urandom_range(3) != 0), acc);
    end

    // Drain outstanding work.
    n = 0;
    do begin
      drive(1'b0, 2'b00, 32'd0, 32'd0, '0, 1'b0, 1'b1, acc);
      n++;
    end while ((sb.size() != 0 || busy) && n < 300);
    check("drain_timeout", 64'(sb.size() != 0 || busy), 64'd0);
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
